// File: rtl/flag_branch_resolver.sv
// Branch resolver on the consumer side of the {Z,V,N} flag register.
// It holds decoded branches until every in-flight flag write has landed, then reports taken/not-taken.
module flag_branch_resolver #(
   parameter int MAX_PEND = 3,
   parameter int CNT_W    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_issue,
   input  logic             flag_wen,
   input  logic [2:0]       flag_d,
   input  logic             flush,
   input  logic             br_valid,
   input  logic [2:0]       br_cond,
   output logic             br_ready,
   output logic             br_done,
   output logic             br_taken,
   output logic [2:0]       flags_q,
   output logic [CNT_W-1:0] pend_q,
   output logic             err_ovf
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(MAX_PEND);
   localparam logic [CNT_W-1:0] PEND_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

   // Flag layout is {Z,V,N}.
   function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] fl);
      logic z;
      logic v;
      logic n;
      logic res;
      z = fl[2];
      v = fl[1];
      n = fl[0];
      case (cond)
         3'd0:    res = ~z;
         3'd1:    res = z;
         3'd2:    res = ~z & ~n;
         3'd3:    res = n;
         3'd4:    res = z | ~n;
         3'd5:    res = z | n;
         3'd6:    res = v;
         3'd7:    res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [2:0]       cond_q;
   logic [2:0]       cond_next;
   logic [2:0]       flags_next;
   logic [CNT_W-1:0] pend_next;
   logic             ovf_set;
   logic             handshake;
   logic             done_q;
   logic             taken_q;

   assign br_ready  = (state == ST_IDLE);
   assign br_done   = done_q;
   assign br_taken  = taken_q;
   assign handshake = br_valid & br_ready & ~flush;

   // Pending counter: saturates at both ends, overflow flagged when an issue is dropped.
   always_comb begin
      pend_next = pend_q;
      ovf_set   = 1'b0;
      if (flag_issue && !flag_wen) begin
         if (pend_q == PEND_MAX) begin
            ovf_set = 1'b1;
         end else begin
            pend_next = pend_q + PEND_ONE;
         end
      end else if (flag_wen && !flag_issue) begin
         if (pend_q == PEND_ZERO) begin
            pend_next = pend_q;
         end else begin
            pend_next = pend_q - PEND_ONE;
         end
      end else begin
         pend_next = pend_q;
      end
   end

   // Next state and held condition; flush only abandons a branch that is still waiting.
   always_comb begin
      state_next = state;
      cond_next  = cond_q;
      flags_next = flag_wen ? flag_d : flags_q;
      case (state)
         ST_IDLE: begin
            if (handshake) begin
               cond_next  = br_cond;
               state_next = (pend_next == PEND_ZERO) ? ST_RESP : ST_WAIT;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else if (pend_next == PEND_ZERO) begin
               state_next = ST_RESP;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, flags and result registers; the result uses the flags committed at the RESP entry edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cond_q  <= 3'd0;
         flags_q <= 3'd0;
         pend_q  <= PEND_ZERO;
         err_ovf <= 1'b0;
         done_q  <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state   <= state_next;
         cond_q  <= cond_next;
         flags_q <= flags_next;
         pend_q  <= pend_next;
         err_ovf <= err_ovf | ovf_set;
         done_q  <= (state_next == ST_RESP);
         taken_q <= (state_next == ST_RESP) & eval_cond(cond_next, flags_next);
      end
   end

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_flag_branch_resolver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flag_issue = 1'b0;
   logic       flag_wen = 1'b0;
   logic [2:0] flag_d = 3'd0;
   logic       flush = 1'b0;
   logic       br_valid = 1'b0;
   logic [2:0] br_cond = 3'd0;
   logic       br_ready;
   logic       br_done;
   logic       br_taken;
   logic [2:0] flags_q;
   logic [1:0] pend_q;
   logic       err_ovf;

   int total = 0;
   int bad = 0;

   // Model: a count of outstanding flag writes, the committed flags, and at most one branch
   // that is either parked (held) or being reported this cycle (resp).
   int       m_pend;
   logic [2:0] m_flags;
   bit       m_err;
   bit       m_held;
   bit       m_resp;
   logic [2:0] m_cond;

   flag_branch_resolver #(.MAX_PEND(3), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flag_issue(flag_issue), .flag_wen(flag_wen),
      .flag_d(flag_d), .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
      .br_ready(br_ready), .br_done(br_done), .br_taken(br_taken),
      .flags_q(flags_q), .pend_q(pend_q), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_taken(input logic [2:0] cond, input logic [2:0] fl);
      bit z, v, n;
      z = fl[2]; v = fl[1]; n = fl[0];
      case (cond)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return z || n;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      m_pend = 0; m_flags = 3'd0; m_err = 0; m_held = 0; m_resp = 0; m_cond = 3'd0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_ready"}, 8'(br_ready), 8'(!m_held && !m_resp));
      chk({tag, "_done"}, 8'(br_done), 8'(m_resp));
      chk({tag, "_taken"}, 8'(br_taken), 8'(m_resp && ref_taken(m_cond, m_flags)));
      chk({tag, "_flags"}, 8'(flags_q), 8'(m_flags));
      chk({tag, "_pend"}, 8'(pend_q), 8'(m_pend));
      chk({tag, "_err"}, 8'(err_ovf), 8'(m_err));
   endtask

   // Called at a falling edge: check, drive, let one rising edge pass, update model, return at next falling edge.
   task automatic cyc(input bit iss, input bit wen, input logic [2:0] d, input bit fl,
                      input bit vld, input logic [2:0] c);
      int pn;
      check_all("cyc");
      flag_issue = iss; flag_wen = wen; flag_d = d; flush = fl; br_valid = vld; br_cond = c;
      @(posedge clk);
      pn = m_pend;
      if (iss && !wen) begin
         if (m_pend == 3) m_err = 1; else pn = m_pend + 1;
      end else if (wen && !iss) begin
         pn = (m_pend > 0) ? m_pend - 1 : 0;
      end
      if (m_resp) m_resp = 0;
      else if (m_held) begin
         if (fl) m_held = 0;
         else if (pn == 0) begin m_held = 0; m_resp = 1; end
      end else if (vld && !fl) begin
         m_cond = c;
         if (pn == 0) m_resp = 1; else m_held = 1;
      end
      if (wen) m_flags = d;
      m_pend = pn;
      @(negedge clk);
      flag_issue = 1'b0; flag_wen = 1'b0; flush = 1'b0; br_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      chk("rst_ready", 8'(br_ready), 8'd1);
      chk("rst_done", 8'(br_done), 8'd0);
      chk("rst_pend", 8'(pend_q), 8'd0);

      // Simple resolve: EQ against Z=1
      cyc(0, 1, 3'b100, 0, 0, 3'd0);
      cyc(0, 0, 3'd0, 0, 1, 3'b001);
      chk("t1_done", 8'(br_done), 8'd1);
      chk("t1_taken", 8'(br_taken), 8'd1);
      chk("t1_flags", 8'(flags_q), 8'b100);
      cyc(0, 0, 3'd0, 0, 0, 3'd0);

      // Two pending writes, LT resolved by the last write
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      chk("t2_pend", 8'(pend_q), 8'd2);
      cyc(0, 0, 3'd0, 0, 1, 3'b011);
      chk("t2_wait_ready", 8'(br_ready), 8'd0);
      cyc(0, 1, 3'b000, 0, 0, 3'd0);
      chk("t2_no_done_yet", 8'(br_done), 8'd0);
      cyc(0, 1, 3'b001, 0, 0, 3'd0);
      chk("t2_done", 8'(br_done), 8'd1);
      chk("t2_taken", 8'(br_taken), 8'd1);
      cyc(0, 0, 3'd0, 0, 0, 3'd0);

      // Handshake coincides with the last flag write
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      cyc(0, 1, 3'b000, 0, 1, 3'b000);
      chk("t3_done", 8'(br_done), 8'd1);
      chk("t3_taken", 8'(br_taken), 8'd1);
      cyc(0, 0, 3'd0, 0, 0, 3'd0);

      // Flush while waiting
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      cyc(0, 0, 3'd0, 0, 1, 3'b111);
      cyc(0, 0, 3'd0, 1, 0, 3'd0);
      chk("t4_ready", 8'(br_ready), 8'd1);
      chk("t4_pend", 8'(pend_q), 8'd1);
      cyc(0, 1, 3'b010, 0, 0, 3'd0);
      chk("t4_no_done", 8'(br_done), 8'd0);
      chk("t4_pend0", 8'(pend_q), 8'd0);

      // Counter limits
      for (int i = 0; i < 3; i++) cyc(1, 0, 3'd0, 0, 0, 3'd0);
      chk("t5_pend3", 8'(pend_q), 8'd3);
      chk("t5_err0", 8'(err_ovf), 8'd0);
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      chk("t5_pend_sat", 8'(pend_q), 8'd3);
      chk("t5_err1", 8'(err_ovf), 8'd1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 3'd0, 0, 0, 3'd0);
      cyc(0, 1, 3'b011, 0, 0, 3'd0);
      chk("t5_pend_floor", 8'(pend_q), 8'd0);
      chk("t5_flags", 8'(flags_q), 8'b011);

      // Full condition sweep
      do_reset();
      for (int f = 0; f < 8; f++) begin
         for (int c = 0; c < 8; c++) begin
            cyc(0, 1, 3'(f), 0, 0, 3'd0);
            cyc(0, 0, 3'd0, 0, 1, 3'(c));
            chk("sweep_taken", 8'(br_taken), 8'(ref_taken(3'(c), 3'(f))));
            cyc(0, 0, 3'd0, 0, 0, 3'd0);
         end
      end

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
             $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      end

      // Asynchronous reset while a branch is parked
      do_reset();
      cyc(1, 0, 3'd0, 0, 0, 3'd0);
      cyc(0, 0, 3'd0, 0, 1, 3'b101);
      chk("t6_wait", 8'(br_ready), 8'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", 8'(br_ready), 8'd1);
      chk("t6_rst_done", 8'(br_done), 8'd0);
      chk("t6_rst_pend", 8'(pend_q), 8'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 3'd0, 0, 0, 3'd0);
      chk("t6_after_done", 8'(br_done), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flag_branch_resolver.md
Name: flag_branch_resolver

Overview:
- Consumer side of the 3-bit ALU flag register {Z,V,N}: holds its own committed copy of the flags and tracks flag-setting instructions in flight.
- Accepts branch requests from decode and stalls them while a flag write is still pending.
- Evaluates the 3-bit condition code against committed flags and reports taken/not-taken to fetch.
- Sits between the decode stage, the ALU flag writeback, and the PC-select logic.

Parameters:
- MAX_PEND, 3, maximum number of flag-setting instructions in flight between issue and flag writeback.
- CNT_W, 2, width of the pending counter; must satisfy 2^CNT_W > MAX_PEND.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flag_issue  input  1  a flag-setting instruction leaves decode this cycle
- flag_wen  input  1  flag writeback strobe, same strobe that writes the flag register
- flag_d  input  3  flag writeback value {Z,V,N}; bit2=Z, bit1=V, bit0=N
- flush  input  1  pipeline flush; abandons any held branch
- br_valid  input  1  decode presents a conditional branch
- br_cond  input  3  condition code of the presented branch
- br_ready  output  1  resolver can accept a branch (high only in IDLE)
- br_done  output  1  one-cycle pulse: branch resolved
- br_taken  output  1  resolution result, meaningful only while br_done=1 (0 otherwise)
- flags_q  output  3  committed flag copy
- pend_q  output  CNT_W  in-flight flag-write count
- err_ovf  output  1  sticky: flag_issue arrived with pend_q==MAX_PEND

Behaviour:
- Reset (rst_n=0, async): flags_q=0, pend_q=0, err_ovf=0, held cond=0, state=IDLE. br_done=0, br_taken=0, br_ready=1.
- Flags: on every edge with flag_wen=1, flags_q<=flag_d, independent of state or flush.
- Pending counter: pend_next = pend_q + flag_issue - flag_wen.
  - issue and wen together leave the count unchanged.
  - wen with pend_q==0 and no issue: flags still written, count saturates at 0.
  - issue with pend_q==MAX_PEND and no wen: count holds and err_ovf<=1, cleared only by reset.
- Accept: a handshake occurs on an edge where br_valid=1, br_ready=1 and flush=0. br_cond is captured at that edge.
- FSM, states IDLE, WAIT, RESP:
  - IDLE: on handshake, go to RESP if pend_next==0, else to WAIT. Otherwise stay in IDLE.
  - WAIT: flush=1 goes to IDLE with no br_done. pend_next==0 goes to RESP. Otherwise stay in WAIT.
  - RESP: br_done=1 and br_taken=eval(cond_q, flags_q); unconditional return to IDLE. flush during RESP does not suppress the pulse.
- Latency:
  - Minimum: handshake at edge T, br_done high in the cycle after T.
  - A flag write landing at the same edge as the handshake is visible in the evaluation, so no extra stall is needed.
  - With pending writes: br_done is high in the cycle after the edge where pend_next reaches 0.
- Condition evaluation (Z,V,N = flags_q):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 UN: 1
- Ordering: flags written while in WAIT but before the count reaches 0 are overwritten by later writes. The evaluation always uses the value from the final write.
- Reset asserted mid-WAIT or mid-RESP: immediate return to the reset values; no br_done is issued.

Test Plan:
- Reset, then flag_wen=1 with flag_d=3'b100; next cycle br_valid=1, br_cond=001 → br_done pulses one cycle later with br_taken=1, and flags_q=100.
- flag_issue twice (pend_q=2), then branch br_cond=011 → state WAIT with br_ready=0. Write flag_d=000, then flag_d=001 → br_done appears the cycle after the second write, with br_taken=1 (N=1).
- Same-edge case: pend_q=1, handshake coincides with flag_wen=1 and flag_d=000, br_cond=000 → no WAIT, br_done the next cycle with br_taken=1.
- Branch held in WAIT, then flush=1 → returns to IDLE, no br_done. pend_q is unchanged, and a later flag_wen decrements it to 0.
- Counter boundaries: 3 issues → pend_q=3; a 4th issue → pend_q stays 3 and err_ovf=1. flag_wen with pend_q=0 → pend_q stays 0 and flags are updated.
- Sweep all 8 br_cond values against all 8 flag combinations with pend_q=0 → br_taken matches the condition evaluation table. Assert rst_n mid-WAIT → br_ready=1, br_done=0, pend_q=0 immediately.
